// File: rtl/dlrom_pkg.sv
// Shared download-ROM definitions for the arcade core: load FSM states and
// the region tags carved out of the download address space.
package dlrom_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } ld_state_e;

    localparam logic [3:0] TAG_PRG    = 4'b0000;
    localparam logic [3:0] TAG_BG     = 4'b1000;
    localparam logic [3:0] TAG_SP0    = 4'b1001;
    localparam logic [3:0] TAG_SP1    = 4'b1010;
    localparam logic [8:0] NVRAM_PAGE = 9'h160;

endpackage

// File: rtl/dl_lane_ram.sv
// One byte-wide simple dual-port lane RAM; the registered read returns the
// old word when read and write hit the same address in the same cycle.
module dl_lane_ram #(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dl_region_rom.sv
// Download-loaded ROM region: snoops the download byte stream, keeps the bytes
// tagged for this region in LANES lane RAMs and serves LANES*8-bit reads.
module dl_region_rom
    import dlrom_pkg::*;
#(
    parameter int               AW         = 13,
    parameter int               LANES      = 2,
    parameter int               DLAW       = 17,
    parameter int               TAG_W      = 4,
    parameter logic [TAG_W-1:0] TAG        = TAG_BG,
    parameter bit               INTERLEAVE = 1'b0,
    localparam int              LG         = $clog2(LANES)
) (
    input  logic               cl,
    input  logic               rst_n,
    input  logic [AW-1:0]      ad,
    output logic [8*LANES-1:0] dt,
    output logic               rd_ok,
    input  logic [DLAW-1:0]    DLAD,
    input  logic [7:0]         DLDT,
    input  logic               DLEN,
    input  logic               DLFIN,
    output logic               ld_busy,
    output logic               ld_done,
    output logic [AW+LG:0]     ld_cnt,
    output logic [7:0]         ld_sum
);

    localparam int LW = (LG > 0) ? LG : 1;
    localparam int CW = AW + LG + 1;

    ld_state_e             state_q, state_d;
    logic                  fin_pend_q, fin_pend_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            sum_q, sum_d;
    logic                  rd_ok_q;
    logic [LANES-1:0]      stg_mask_q, stg_mask_d;
    logic [AW-1:0]         stg_word_q, stg_word_d;
    logic [LANES-1:0][7:0] stg_data_q, stg_data_d;
    logic [LANES-1:0][7:0] rd_data;

    logic [AW-1:0]    dl_word;
    logic [LW-1:0]    dl_lane;
    logic [LANES-1:0] lane_oh;
    logic             hit, accept, commit;

    assign hit    = DLEN && (DLAD[DLAW-1 -: TAG_W] == TAG);
    assign accept = hit && (state_q != ST_FLUSH);

    generate
        if (LANES == 1) begin : g_one_lane
            assign dl_lane = '0;
            assign dl_word = DLAD[AW-1:0];
        end else if (INTERLEAVE) begin : g_interleaved
            assign dl_lane = DLAD[LG-1:0];
            assign dl_word = DLAD[AW+LG-1:LG];
        end else begin : g_linear
            assign dl_lane = DLAD[AW+LG-1:AW];
            assign dl_word = DLAD[AW-1:0];
        end
    endgenerate

    assign lane_oh = LANES'(1) << dl_lane;

    // A staged word goes out when complete, when the stream moves to another
    // word, or when the load ends; staged lanes are written together.
    assign commit = INTERLEAVE && ((&stg_mask_q)
                  || ((state_q == ST_FLUSH) && (|stg_mask_q))
                  || (accept && (|stg_mask_q) && (dl_word != stg_word_q)));

    always_comb begin
        state_d    = state_q;
        fin_pend_d = fin_pend_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (hit) begin
                    state_d    = ST_LOADING;
                    fin_pend_d = DLFIN;
                    cnt_d      = CW'(1);
                    sum_d      = DLDT;
                end
            end
            ST_LOADING: begin
                if (hit) begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    sum_d = sum_q + DLDT;
                end
                if (DLFIN || fin_pend_q) begin
                    state_d    = ST_FLUSH;
                    fin_pend_d = 1'b0;
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stg_mask_d = commit ? '0 : stg_mask_q;
        stg_word_d = stg_word_q;
        stg_data_d = stg_data_q;
        if (INTERLEAVE && accept) begin
            stg_mask_d          = stg_mask_d | lane_oh;
            stg_word_d          = dl_word;
            stg_data_d[dl_lane] = DLDT;
        end
    end

    always_ff @(posedge cl) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fin_pend_q <= 1'b0;
            cnt_q      <= '0;
            sum_q      <= '0;
            rd_ok_q    <= 1'b0;
            stg_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            fin_pend_q <= fin_pend_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            rd_ok_q    <= (state_q == ST_DONE);
            stg_mask_q <= stg_mask_d;
        end
    end

    always_ff @(posedge cl) begin
        stg_word_q <= stg_word_d;
        stg_data_q <= stg_data_d;
    end

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic          we;
            logic [AW-1:0] waddr;
            logic [7:0]    wdata;

            // Writes are held off during reset so staged bytes never land.
            assign we    = rst_n && (INTERLEAVE ? (commit && stg_mask_q[l])
                                                : (accept && lane_oh[l]));
            assign waddr = INTERLEAVE ? stg_word_q : dl_word;
            assign wdata = INTERLEAVE ? stg_data_q[l] : DLDT;

            dl_lane_ram #(.AW(AW)) u_ram (
                .clk     (cl),
                .we_i    (we),
                .waddr_i (waddr),
                .wdata_i (wdata),
                .raddr_i (ad),
                .rdata_o (rd_data[l])
            );
        end
    endgenerate

    assign dt      = rd_ok_q ? rd_data : '0;
    assign rd_ok   = rd_ok_q;
    assign ld_busy = (state_q == ST_LOADING) || (state_q == ST_FLUSH);
    assign ld_done = (state_q == ST_DONE);
    assign ld_cnt  = cnt_q;
    assign ld_sum  = sum_q;

endmodule

// File: tb/tb_dl_region_rom.sv
// Bench for dl_region_rom: linear and interleaved instances share one download
// stream and are checked every cycle against a byte-addressed region model.
module tb_dl_region_rom;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ad;
    logic [8:0]  dla;
    logic [7:0]  dldt;
    logic        dlen, dlfin;
    logic [15:0] dt0, dt1;
    logic        rdok0, rdok1, busy0, busy1, done0, done1;
    logic [5:0]  cnt0, cnt1;
    logic [7:0]  sum0, sum1;

    int checks = 0;
    int errors = 0;

    // model: state 0 idle, 1 loading, 2 flush, 3 done
    int         mst;
    int         mcnt, msum;
    bit         mfinp;
    logic [7:0] m0 [32];
    logic [7:0] m1 [32];
    logic [7:0] pv [2];
    bit   [1:0] pmask;
    int         pword;

    always #5 clk = ~clk;

    dl_region_rom #(.AW(4), .LANES(2), .DLAW(9), .TAG_W(4), .TAG(4'b1000), .INTERLEAVE(1'b0)) u_dut0 (
        .cl(clk), .rst_n(rst_n), .ad(ad), .dt(dt0), .rd_ok(rdok0),
        .DLAD(dla), .DLDT(dldt), .DLEN(dlen), .DLFIN(dlfin),
        .ld_busy(busy0), .ld_done(done0), .ld_cnt(cnt0), .ld_sum(sum0)
    );

    dl_region_rom #(.AW(4), .LANES(2), .DLAW(9), .TAG_W(4), .TAG(4'b1000), .INTERLEAVE(1'b1)) u_dut1 (
        .cl(clk), .rst_n(rst_n), .ad(ad), .dt(dt1), .rd_ok(rdok1),
        .DLAD(dla), .DLDT(dldt), .DLEN(dlen), .DLFIN(dlfin),
        .ld_busy(busy1), .ld_done(done1), .ld_cnt(cnt1), .ld_sum(sum1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic commit_pend();
        for (int l = 0; l < 2; l++)
            if (pmask[l]) m1[2*pword+l] = pv[l];
        pmask = 2'b00;
    endtask

    // Region seen as 32 bytes; interleaved mode holds bytes of one word
    // back until that word completes, changes, or the load ends.
    task automatic accept_byte(input bit [4:0] off, input bit [7:0] b);
        int w, l;
        m0[off] = b;
        w = int'(off) / 2;
        l = int'(off) % 2;
        if (pmask != 2'b00 && w != pword) commit_pend();
        pword    = w;
        pv[l]    = b;
        pmask[l] = 1'b1;
        if (pmask == 2'b11) commit_pend();
    endtask

    task automatic model_edge(input bit rst, input bit en, input bit [3:0] tag,
                              input bit [4:0] off, input bit [7:0] b, input bit fin);
        bit hit;
        if (!rst) begin
            mst = 0; mcnt = 0; msum = 0; mfinp = 1'b0; pmask = 2'b00;
            return;
        end
        hit = en && (tag == 4'b1000);
        case (mst)
            0, 3: if (hit) begin
                mst = 1; mcnt = 1; msum = b; mfinp = fin;
                accept_byte(off, b);
            end
            1: begin
                if (hit) begin
                    if (mcnt < 63) mcnt++;
                    msum = (msum + b) % 256;
                    accept_byte(off, b);
                end
                if (fin || mfinp) begin mst = 2; mfinp = 1'b0; end
            end
            default: begin commit_pend(); mst = 3; end
        endcase
    endtask

    task automatic step(input bit rst, input bit en, input bit [3:0] tag, input bit [4:0] off,
                        input bit [7:0] b, input bit fin, input bit [3:0] a);
        logic [15:0] e0, e1;
        bit          eok;
        int          ia;
        rst_n = rst; dlen = en; dla = {tag, off}; dldt = b; dlfin = fin; ad = a;
        @(posedge clk);
        ia  = int'(a);
        eok = rst && (mst == 3);
        e0  = eok ? {m0[16+ia], m0[ia]} : 16'h0;
        e1  = eok ? {m1[2*ia+1], m1[2*ia]} : 16'h0;
        model_edge(rst, en, tag, off, b, fin);
        #1;
        chk("dt_lin", dt0, e0);
        chk("dt_il", dt1, e1);
        chk("rdok_lin", rdok0, eok);
        chk("rdok_il", rdok1, eok);
        chk("busy_lin", busy0, (mst == 1 || mst == 2));
        chk("busy_il", busy1, (mst == 1 || mst == 2));
        chk("done_lin", done0, (mst == 3));
        chk("done_il", done1, (mst == 3));
        chk("cnt_lin", cnt0, mcnt);
        chk("cnt_il", cnt1, mcnt);
        chk("sum_lin", sum0, msum);
        chk("sum_il", sum1, msum);
    endtask

    task automatic idle(input bit [3:0] a);
        step(1'b1, 1'b0, 4'h8, 5'd0, 8'h00, 1'b0, a);
    endtask

    task automatic hitb(input bit [4:0] off, input bit [7:0] b);
        step(1'b1, 1'b1, 4'h8, off, b, 1'b0, 4'd0);
    endtask

    task automatic fin();
        step(1'b1, 1'b0, 4'h8, 5'd0, 8'h00, 1'b1, 4'd0);
    endtask

    initial begin
        rst_n = 1'b0; ad = '0; dla = '0; dldt = '0; dlen = 1'b0; dlfin = 1'b0;
        mst = 0; mcnt = 0; msum = 0; mfinp = 1'b0; pmask = 2'b00; pword = 0;

        step(1'b0, 1'b0, 4'h8, 5'd0, 8'h00, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'h8, 5'd1, 8'h55, 1'b0, 4'd1);

        // full linear load, byte value = offset
        for (int i = 0; i < 32; i++) hitb(5'(i), 8'(i));
        fin();
        chk("t1_busy_after_fin", busy0, 1'b1);
        idle(4'd0);
        chk("t1_done", done0, 1'b1);
        idle(4'd3);
        chk("t1_dt", dt0, 16'h1303);
        chk("t1_cnt", cnt0, 6'd32);
        chk("t1_sum", sum0, 8'hF0);
        idle(4'd3);

        // word 5 both lanes in the interleaved layout
        hitb(5'd10, 8'hAA);
        hitb(5'd11, 8'hBB);
        fin(); idle(4'd0); idle(4'd5);
        chk("t2_dt", dt1, 16'hBBAA);
        chk("t2_rdok", rdok1, 1'b1);

        // partial word 7, lane 0 only
        hitb(5'd14, 8'h11);
        fin(); idle(4'd0); idle(4'd7);
        chk("t3_dt", dt1, 16'h0F11);

        // foreign tags only keep IDLE; mixed traffic counts only hits
        step(1'b0, 1'b0, 4'h8, 5'd0, 8'h00, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b1001, 5'(i), 8'h77, 1'b0, 4'd0);
        chk("t4_idle", {busy0, done0, busy1, done1}, 4'b0000);
        hitb(5'd20, 8'h21);
        step(1'b1, 1'b1, 4'b1001, 5'd21, 8'h99, 1'b0, 4'd0);
        hitb(5'd21, 8'h42);
        step(1'b1, 1'b1, 4'b1001, 5'd3, 8'h98, 1'b1, 4'd0);
        idle(4'd0); idle(4'd10);
        chk("t4_cnt", cnt1, 6'd2);
        chk("t4_dt", dt1, 16'h4221);

        // reset with lane 0 of word 9 staged
        hitb(5'd18, 8'h5A);
        step(1'b0, 1'b0, 4'h8, 5'd0, 8'h00, 1'b0, 4'd9);
        chk("t5_state", {busy1, done1}, 2'b00);
        chk("t5_cnt", cnt1, 6'd0);
        chk("t5_dt", dt1, 16'h0000);
        hitb(5'd5, 8'h77);
        fin(); idle(4'd0); idle(4'd9);
        chk("t5_absent", dt1, 16'h1312);

        // hit together with DLFIN while DONE
        step(1'b1, 1'b1, 4'h8, 5'd0, 8'h3C, 1'b1, 4'd0);
        chk("t6_busy", busy0, 1'b1);
        chk("t6_cnt", cnt0, 6'd1);
        chk("t6_sum", sum0, 8'h3C);
        idle(4'd0); idle(4'd0); idle(4'd0);
        chk("t6_rdok", rdok0, 1'b1);
        idle(4'd0);

        // count saturates at all-ones
        for (int i = 0; i < 70; i++) hitb(5'($urandom), 8'($urandom));
        fin(); idle(4'd0); idle(4'd0);
        chk("sat_cnt", cnt0, 6'h3F);

        for (int s = 0; s < 25; s++) begin
            int         n, r;
            bit   [3:0] ft;
            n = $urandom_range(30, 5);
            for (int i = 0; i < n; i++) begin
                r  = $urandom_range(3, 0);
                ft = 4'($urandom_range(15, 0));
                if (ft == 4'h8) ft = 4'h9;
                if (r == 0)      step(1'b1, 1'b0, 4'h8, 5'($urandom), 8'($urandom), 1'b0, 4'($urandom));
                else if (r == 1) step(1'b1, 1'b1, ft, 5'($urandom), 8'($urandom), 1'b0, 4'($urandom));
                else             step(1'b1, 1'b1, 4'h8, 5'($urandom), 8'($urandom), 1'b0, 4'($urandom));
            end
            step(1'b1, 1'($urandom_range(1, 0)), 4'h8, 5'($urandom), 8'($urandom), 1'b1, 4'($urandom));
            for (int i = 0; i < 6; i++) idle(4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
